// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: merges load returns, ALU results and two
// coprocessor results onto one registered write port, with a busy scoreboard.
module rf_wb_arb #(
  parameter int LDQ_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        SYSCLK,
  input  logic        RESET_D1_R,
  input  logic        ALU_WE_M,
  input  logic [4:0]  ALU_ADDR_M,
  input  logic [31:0] ALU_DATA_M,
  input  logic        LD_ISSUE_E,
  input  logic [4:0]  LD_ADDR_E,
  input  logic        LD_VALID,
  input  logic [31:0] LD_DATA,
  input  logic        CE0_ISSUE_E,
  input  logic [4:0]  CE0_ADDR_E,
  input  logic        CE0_VALID,
  input  logic [31:0] CE0_DATA,
  output logic        CE0_READY,
  input  logic        CE1_ISSUE_E,
  input  logic [4:0]  CE1_ADDR_E,
  input  logic        CE1_VALID,
  input  logic [31:0] CE1_DATA,
  output logic        CE1_READY,
  input  logic [4:0]  REGAADDR_S,
  input  logic [4:0]  REGBADDR_S,
  output logic        WRITEC_W_R,
  output logic [4:0]  REGCADDR_W_R,
  output logic [31:0] REGC_W_R,
  output logic        HAZARD_S,
  output logic        WB_STALL_M,
  output logic        LDQ_FULL,
  output logic        PROTO_ERR
);

  localparam int             PTR_W      = $clog2(LDQ_DEPTH);
  localparam logic [PTR_W:0] LDQ_MAX    = (PTR_W + 1)'(LDQ_DEPTH);
  localparam logic [3:0]     STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_LD,
    SRC_ALU,
    SRC_CE0,
    SRC_CE1
  } src_e;

  logic [4:0]       ldq_mem [LDQ_DEPTH];
  logic [PTR_W-1:0] ldq_rd;
  logic [PTR_W-1:0] ldq_wr;
  logic [PTR_W:0]   ldq_cnt;
  logic [1:0]       ce_pend;
  logic [4:0]       ce0_dest;
  logic [4:0]       ce1_dest;
  logic             rr_ptr;
  logic [3:0]       starve_cnt;
  logic [31:0]      busy;
  logic [31:0]      busy_next;

  logic             ldq_empty;
  logic             ld_pop;
  logic             ld_push;
  logic [1:0]       ce_req;
  logic [1:0]       ce_issue;
  logic             ce_pick;
  logic             forced;
  logic             ce_grant;
  logic             err_now;
  src_e             src;
  logic [4:0]       gnt_addr;
  logic [31:0]      gnt_data;

  assign LDQ_FULL   = (ldq_cnt == LDQ_MAX);
  assign CE0_READY  = (src == SRC_CE0);
  assign CE1_READY  = (src == SRC_CE1);
  assign WB_STALL_M = ALU_WE_M && (src != SRC_ALU);
  assign HAZARD_S   = busy[REGAADDR_S] | busy[REGBADDR_S];

  // Grant selection: load return, then a starved CE, then ALU, then CE round-robin.
  always_comb begin
    ldq_empty = (ldq_cnt == '0);
    ld_pop    = LD_VALID && !ldq_empty;
    ld_push   = LD_ISSUE_E && (!LDQ_FULL || ld_pop);
    ce_req    = {CE1_VALID & ce_pend[1], CE0_VALID & ce_pend[0]};
    ce_issue  = {CE1_ISSUE_E & ~ce_pend[1], CE0_ISSUE_E & ~ce_pend[0]};
    ce_pick   = (ce_req == 2'b11) ? rr_ptr : ce_req[1];
    forced    = (starve_cnt == STARVE_MAX) && (ce_req != 2'b00);

    src = SRC_NONE;
    if (ld_pop)                  src = SRC_LD;
    else if (forced)             src = ce_pick ? SRC_CE1 : SRC_CE0;
    else if (ALU_WE_M)           src = SRC_ALU;
    else if (ce_req != 2'b00)    src = ce_pick ? SRC_CE1 : SRC_CE0;

    gnt_addr = '0;
    gnt_data = '0;
    unique case (src)
      SRC_LD:  begin gnt_addr = ldq_mem[ldq_rd]; gnt_data = LD_DATA;    end
      SRC_ALU: begin gnt_addr = ALU_ADDR_M;      gnt_data = ALU_DATA_M; end
      SRC_CE0: begin gnt_addr = ce0_dest;        gnt_data = CE0_DATA;   end
      SRC_CE1: begin gnt_addr = ce1_dest;        gnt_data = CE1_DATA;   end
      default: ;
    endcase
    ce_grant = (src == SRC_CE0) || (src == SRC_CE1);

    // Issue sets are applied after the grant clear so a same-cycle set wins.
    busy_next = busy;
    if (src != SRC_NONE) busy_next[gnt_addr]   = 1'b0;
    if (ld_push)         busy_next[LD_ADDR_E]  = 1'b1;
    if (ce_issue[0])     busy_next[CE0_ADDR_E] = 1'b1;
    if (ce_issue[1])     busy_next[CE1_ADDR_E] = 1'b1;
    busy_next[0] = 1'b0;

    err_now = (LD_VALID && ldq_empty) ||
              (LD_ISSUE_E && LDQ_FULL && !ld_pop) ||
              (CE0_ISSUE_E && ce_pend[0]) || (CE1_ISSUE_E && ce_pend[1]) ||
              (CE0_VALID && !ce_pend[0]) || (CE1_VALID && !ce_pend[1]);
  end

  always_ff @(posedge SYSCLK) begin
    if (ld_push) ldq_mem[ldq_wr] <= LD_ADDR_E;
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET_D1_R) begin
      ldq_rd       <= '0;
      ldq_wr       <= '0;
      ldq_cnt      <= '0;
      ce_pend      <= '0;
      ce0_dest     <= '0;
      ce1_dest     <= '0;
      rr_ptr       <= 1'b0;
      starve_cnt   <= '0;
      busy         <= '0;
      PROTO_ERR    <= 1'b0;
      WRITEC_W_R   <= 1'b0;
      REGCADDR_W_R <= '0;
      REGC_W_R     <= '0;
    end else begin
      if (ld_push) ldq_wr <= ldq_wr + 1'b1;
      if (ld_pop)  ldq_rd <= ldq_rd + 1'b1;
      case ({ld_push, ld_pop})
        2'b10:   ldq_cnt <= ldq_cnt + 1'b1;
        2'b01:   ldq_cnt <= ldq_cnt - 1'b1;
        default: ;
      endcase

      if (src == SRC_CE0) begin
        ce_pend[0] <= 1'b0;
      end else if (ce_issue[0]) begin
        ce_pend[0] <= 1'b1;
        ce0_dest   <= CE0_ADDR_E;
      end
      if (src == SRC_CE1) begin
        ce_pend[1] <= 1'b0;
      end else if (ce_issue[1]) begin
        ce_pend[1] <= 1'b1;
        ce1_dest   <= CE1_ADDR_E;
      end

      // Counter holds at the limit so the forced CE stays forced until served.
      if (ce_grant) begin
        starve_cnt <= '0;
        rr_ptr     <= ~rr_ptr;
      end else if ((CE0_VALID || CE1_VALID) && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      busy <= busy_next;
      if (err_now) PROTO_ERR <= 1'b1;

      WRITEC_W_R   <= (src != SRC_NONE) && (gnt_addr != 5'd0);
      REGCADDR_W_R <= gnt_addr;
      REGC_W_R     <= gnt_data;
    end
  end

endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_rf_wb_arb;

  localparam int LDQ_DEPTH    = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_addr;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ce0_issue, ce1_issue;
  logic [4:0]  ce0_addr, ce1_addr;
  logic        ce0_valid, ce1_valid;
  logic [31:0] ce0_data, ce1_data;
  logic        ce0_ready, ce1_ready;
  logic [4:0]  ra, rb;
  logic        writec;
  logic [4:0]  regc_addr;
  logic [31:0] regc;
  logic        hazard, stall, ldq_full, proto_err;

  int checks   = 0;
  int failures = 0;

  logic s_stall, s_hazard, s_ready0, s_ready1;

  always #5 clk = ~clk;

  rf_wb_arb #(.LDQ_DEPTH(LDQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .SYSCLK(clk), .RESET_D1_R(rst),
    .ALU_WE_M(alu_we), .ALU_ADDR_M(alu_addr), .ALU_DATA_M(alu_data),
    .LD_ISSUE_E(ld_issue), .LD_ADDR_E(ld_addr), .LD_VALID(ld_valid), .LD_DATA(ld_data),
    .CE0_ISSUE_E(ce0_issue), .CE0_ADDR_E(ce0_addr), .CE0_VALID(ce0_valid),
    .CE0_DATA(ce0_data), .CE0_READY(ce0_ready),
    .CE1_ISSUE_E(ce1_issue), .CE1_ADDR_E(ce1_addr), .CE1_VALID(ce1_valid),
    .CE1_DATA(ce1_data), .CE1_READY(ce1_ready),
    .REGAADDR_S(ra), .REGBADDR_S(rb),
    .WRITEC_W_R(writec), .REGCADDR_W_R(regc_addr), .REGC_W_R(regc),
    .HAZARD_S(hazard), .WB_STALL_M(stall), .LDQ_FULL(ldq_full), .PROTO_ERR(proto_err)
  );

  typedef struct packed {
    logic        alu_we;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_addr;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        exp_stall;
    logic        exp_hazard;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_full;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(
    input logic aw, input logic [4:0] aa, input logic [31:0] ad,
    input logic li, input logic [4:0] la, input logic lv, input logic [31:0] ldat,
    input logic [4:0] a, input logic [4:0] b,
    input logic es, input logic eh, input logic ew, input logic [4:0] ea,
    input logic [31:0] ed, input logic ef, input logic ee);
    vec_t v;
    v = '{aw, aa, ad, li, la, lv, ldat, a, b, es, eh, ew, ea, ed, ef, ee};
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    alu_we = 0; alu_addr = 0; alu_data = 0;
    ld_issue = 0; ld_addr = 0; ld_valid = 0; ld_data = 0;
    ce0_issue = 0; ce0_addr = 0; ce0_valid = 0; ce0_data = 0;
    ce1_issue = 0; ce1_addr = 0; ce1_valid = 0; ce1_data = 0;
    ra = 0; rb = 0;
  endtask

  task automatic sample_comb();
    @(negedge clk);
    s_stall  = stall;
    s_hazard = hazard;
    s_ready0 = ce0_ready;
    s_ready1 = ce1_ready;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_comb();
    finish_cycle();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    clear_inputs();
    alu_we = v.alu_we; alu_addr = v.alu_addr; alu_data = v.alu_data;
    ld_issue = v.ld_issue; ld_addr = v.ld_addr;
    ld_valid = v.ld_valid; ld_data = v.ld_data;
    ra = v.ra; rb = v.rb;
  endtask

  // Reference model: pending loads kept as a FIFO queue of destinations.
  int          m_ldq[$];
  bit          m_pend [2];
  logic [4:0]  m_dest [2];
  bit   [31:0] m_busy;
  bit          m_rr;
  int          m_starve;
  bit          m_err;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_win;

  task automatic model_reset();
    m_ldq.delete();
    m_pend[0] = 0; m_pend[1] = 0;
    m_dest[0] = 0; m_dest[1] = 0;
    m_busy = 0; m_rr = 0; m_starve = 0; m_err = 0;
    m_we = 0; m_addr = 0; m_data = 0; m_win = 0;
  endtask

  // Winner codes: 0 none, 1 load, 2 CE0, 3 CE1, 4 ALU.
  task automatic model_decide();
    bit ok0, ok1;
    int ce_choice;
    ok0 = ce0_valid && m_pend[0];
    ok1 = ce1_valid && m_pend[1];
    ce_choice = (ok0 && ok1) ? (m_rr ? 3 : 2) : (ok1 ? 3 : 2);
    if (ld_valid && m_ldq.size() > 0)              m_win = 1;
    else if ((ok0 || ok1) && m_starve == STARVE_LIMIT) m_win = ce_choice;
    else if (alu_we)                              m_win = 4;
    else if (ok0 || ok1)                          m_win = ce_choice;
    else                                          m_win = 0;
  endtask

  task automatic model_commit();
    int g_addr;
    logic [31:0] g_data;
    bit take_ld, take_ce0, take_ce1;
    g_addr = 0; g_data = 0;
    case (m_win)
      1: begin g_addr = m_ldq[0];  g_data = ld_data;  end
      2: begin g_addr = m_dest[0]; g_data = ce0_data; end
      3: begin g_addr = m_dest[1]; g_data = ce1_data; end
      4: begin g_addr = alu_addr;  g_data = alu_data; end
      default: ;
    endcase
    if (ld_valid && m_ldq.size() == 0) m_err = 1;
    take_ld = ld_issue && (m_ldq.size() < LDQ_DEPTH || m_win == 1);
    if (ld_issue && !take_ld) m_err = 1;
    take_ce0 = ce0_issue && !m_pend[0];
    take_ce1 = ce1_issue && !m_pend[1];
    if ((ce0_issue && m_pend[0]) || (ce1_issue && m_pend[1])) m_err = 1;
    if ((ce0_valid && !m_pend[0]) || (ce1_valid && !m_pend[1])) m_err = 1;
    if (m_win == 1) void'(m_ldq.pop_front());
    if (take_ld) m_ldq.push_back(ld_addr);
    if (m_win == 2) m_pend[0] = 0;
    if (m_win == 3) m_pend[1] = 0;
    if (take_ce0) begin m_pend[0] = 1; m_dest[0] = ce0_addr; end
    if (take_ce1) begin m_pend[1] = 1; m_dest[1] = ce1_addr; end
    if (m_win != 0) m_busy[g_addr] = 0;
    if (take_ld)  m_busy[ld_addr]  = 1;
    if (take_ce0) m_busy[ce0_addr] = 1;
    if (take_ce1) m_busy[ce1_addr] = 1;
    m_busy[0] = 0;
    if (m_win == 2 || m_win == 3) begin
      m_starve = 0;
      m_rr = !m_rr;
    end else if ((ce0_valid || ce1_valid) && m_starve < STARVE_LIMIT) begin
      m_starve++;
    end
    m_we   = (m_win != 0) && (g_addr != 0);
    m_addr = 5'(g_addr);
    m_data = g_data;
  endtask

  task automatic randomize_inputs();
    alu_we    = ($urandom_range(0, 4) != 0);
    alu_addr  = 5'($urandom);
    alu_data  = $urandom;
    ld_issue  = ($urandom_range(0, 3) == 0);
    ld_addr   = 5'($urandom);
    ld_valid  = (m_ldq.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
    ld_data   = $urandom;
    ce0_issue = m_pend[0] ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 2) == 0);
    ce1_issue = m_pend[1] ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 2) == 0);
    ce0_addr  = 5'($urandom);
    ce1_addr  = 5'($urandom);
    ce0_valid = m_pend[0] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 199) == 0);
    ce1_valid = m_pend[1] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 199) == 0);
    ce0_data  = $urandom;
    ce1_data  = $urandom;
    ra        = 5'($urandom);
    rb        = 5'($urandom);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_ready;
    logic stall_at_ready;

    rst = 1;
    clear_inputs();
    repeat (2) tick();
    rst = 0;
    check_output("reset_writec", writec, 0);
    check_output("reset_regc", regc, 0);
    check_output("reset_full", ldq_full, 0);
    check_output("reset_err", proto_err, 0);

    // Directed vectors: ALU write, load priority over ALU, r0 handling, full/overflow.
    vecs[0]  = mk(1, 5, 'h1234, 0, 0,  0, 0,       0,  0,  0, 0, 1, 5,  'h1234, 0, 0);
    vecs[1]  = mk(0, 0, 0,      1, 7,  0, 0,       7,  0,  0, 0, 0, 0,  0,      0, 0);
    vecs[2]  = mk(0, 0, 0,      0, 0,  0, 0,       7,  0,  0, 1, 0, 0,  0,      0, 0);
    vecs[3]  = mk(1, 3, 'h33,   0, 0,  1, 'hAAAA,  7,  0,  1, 1, 1, 7,  'hAAAA, 0, 0);
    vecs[4]  = mk(1, 3, 'h33,   0, 0,  0, 0,       7,  0,  0, 0, 1, 3,  'h33,   0, 0);
    vecs[5]  = mk(0, 0, 0,      1, 0,  0, 0,       0,  0,  0, 0, 0, 0,  0,      0, 0);
    vecs[6]  = mk(0, 0, 0,      0, 0,  1, 'h55,    0,  0,  0, 0, 0, 0,  0,      0, 0);
    vecs[7]  = mk(1, 0, 'h77,   0, 0,  0, 0,       0,  0,  0, 0, 0, 0,  0,      0, 0);
    vecs[8]  = mk(0, 0, 0,      1, 8,  0, 0,       0,  0,  0, 0, 0, 0,  0,      0, 0);
    vecs[9]  = mk(0, 0, 0,      1, 9,  0, 0,       8,  0,  0, 1, 0, 0,  0,      1, 0);
    vecs[10] = mk(0, 0, 0,      1, 10, 0, 0,       9,  10, 0, 1, 0, 0,  0,      1, 1);
    vecs[11] = mk(0, 0, 0,      1, 12, 1, 'h888,   10, 0,  0, 0, 1, 8,  'h888,  1, 1);
    vecs[12] = mk(0, 0, 0,      0, 0,  1, 'h999,   12, 0,  0, 1, 1, 9,  'h999,  0, 1);
    vecs[13] = mk(0, 0, 0,      0, 0,  1, 'hBBB,   12, 0,  0, 1, 1, 12, 'hBBB,  0, 1);
    vecs[14] = mk(0, 0, 0,      0, 0,  0, 0,       12, 0,  0, 0, 0, 0,  0,      0, 1);

    for (int r = 0; r < 15; r++) begin
      apply_stimulus(vecs[r]);
      sample_comb();
      check_output($sformatf("vec%0d_stall", r), s_stall, vecs[r].exp_stall);
      check_output($sformatf("vec%0d_hazard", r), s_hazard, vecs[r].exp_hazard);
      finish_cycle();
      check_output($sformatf("vec%0d_writec", r), writec, vecs[r].exp_we);
      if (vecs[r].exp_we) begin
        check_output($sformatf("vec%0d_waddr", r), regc_addr, vecs[r].exp_addr);
        check_output($sformatf("vec%0d_wdata", r), regc, vecs[r].exp_data);
      end
      check_output($sformatf("vec%0d_full", r), ldq_full, vecs[r].exp_full);
      check_output($sformatf("vec%0d_err", r), proto_err, vecs[r].exp_err);
    end

    // Starvation: CE0 waits behind a continuous ALU stream until forced.
    do_reset();
    ce0_issue = 1; ce0_addr = 12;
    tick();
    ce0_issue = 0;
    ce0_valid = 1; ce0_data = 'hC0C0;
    alu_we = 1; alu_addr = 4; alu_data = 'h44;
    first_ready = -1;
    stall_at_ready = 0;
    for (int c = 1; c <= 10 && first_ready < 0; c++) begin
      sample_comb();
      if (s_ready0) begin
        first_ready = c;
        stall_at_ready = s_stall;
      end
      finish_cycle();
    end
    check_output("starve_ready_cycle", first_ready, 5);
    check_output("starve_stall", stall_at_ready, 1);
    check_output("starve_writec", writec, 1);
    check_output("starve_waddr", regc_addr, 12);
    check_output("starve_wdata", regc, 'hC0C0);
    check_output("starve_err", proto_err, 0);

    // Round-robin between both coprocessors.
    do_reset();
    ce0_issue = 1; ce0_addr = 10; ce1_issue = 1; ce1_addr = 11;
    tick();
    ce0_issue = 0; ce1_issue = 0;
    ce0_valid = 1; ce0_data = 'hA0; ce1_valid = 1; ce1_data = 'hB1;
    sample_comb();
    check_output("rr1_ready0", s_ready0, 1);
    check_output("rr1_ready1", s_ready1, 0);
    finish_cycle();
    check_output("rr1_waddr", regc_addr, 10);
    check_output("rr1_wdata", regc, 'hA0);
    ce0_valid = 0;
    sample_comb();
    check_output("rr2_ready0", s_ready0, 0);
    check_output("rr2_ready1", s_ready1, 1);
    finish_cycle();
    check_output("rr2_waddr", regc_addr, 11);
    check_output("rr2_wdata", regc, 'hB1);
    ce1_valid = 0;
    sample_comb();
    check_output("rr3_ready0", s_ready0, 0);
    check_output("rr3_ready1", s_ready1, 0);
    finish_cycle();
    check_output("rr3_writec", writec, 0);
    check_output("rr3_err", proto_err, 0);
    ce0_issue = 1; ce0_addr = 13; ce1_issue = 1; ce1_addr = 11;
    tick();
    ce0_issue = 0; ce1_issue = 0;
    ce0_valid = 1; ce1_valid = 1;
    sample_comb();
    check_output("rr4_ready0", s_ready0, 1);
    finish_cycle();

    // Protocol error, then reset in the middle of an ALU grant.
    ce0_valid = 0;
    ld_valid = 1; ld_data = 'hDEAD;
    alu_we = 1; alu_addr = 6; alu_data = 'h66;
    tick();
    check_output("err_sticky", proto_err, 1);
    check_output("err_alu_waddr", regc_addr, 6);
    ld_valid = 0;
    rst = 1;
    tick();
    check_output("rst_writec", writec, 0);
    check_output("rst_waddr", regc_addr, 0);
    check_output("rst_wdata", regc, 0);
    check_output("rst_err", proto_err, 0);
    check_output("rst_full", ldq_full, 0);
    rst = 0;
    clear_inputs();
    ra = 11; rb = 13;
    sample_comb();
    check_output("rst_hazard", s_hazard, 0);
    check_output("rst_stall", s_stall, 0);
    check_output("rst_ready0", s_ready0, 0);
    check_output("rst_ready1", s_ready1, 0);
    finish_cycle();

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 800; i++) begin
      randomize_inputs();
      sample_comb();
      model_decide();
      check_output("rnd_stall", s_stall, alu_we && (m_win != 4));
      check_output("rnd_ready0", s_ready0, m_win == 2);
      check_output("rnd_ready1", s_ready1, m_win == 3);
      check_output("rnd_hazard", s_hazard, m_busy[ra] | m_busy[rb]);
      model_commit();
      finish_cycle();
      check_output("rnd_writec", writec, m_we);
      if (m_we) begin
        check_output("rnd_waddr", regc_addr, m_addr);
        check_output("rnd_wdata", regc, m_data);
      end
      check_output("rnd_full", ldq_full, m_ldq.size() == LDQ_DEPTH);
      check_output("rnd_err", proto_err, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arb.md
RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 Parameter LDQ_DEPTH, 2, depth of the outstanding-load destination queue (power of two, 2..8).
REQ-002 Parameter STARVE_LIMIT, 4, consecutive lost CE-request cycles before a CE is forced ahead of the ALU (1..15).
REQ-003 SYSCLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 RESET_D1_R  in  1  reset, synchronous, active-high.
REQ-005 ALU_WE_M / ALU_ADDR_M / ALU_DATA_M  in  1/5/32  ALU writeback request, destination and data; held by the source while WB_STALL_M is high.
REQ-006 LD_ISSUE_E / LD_ADDR_E  in  1/5  load issued, with its destination register.
REQ-007 LD_VALID / LD_DATA  in  1/32  load return; cannot be back-pressured; returns arrive in issue order.
REQ-008 CEn_ISSUE_E / CEn_ADDR_E (n=0,1)  in  1/5  coprocessor op issued, with its destination register.
REQ-009 CEn_VALID / CEn_DATA  in  1/32  coprocessor result request.
REQ-010 CEn_READY  out  1  result accepted; a transfer occurs when VALID and READY are both high.
REQ-011 REGAADDR_S / REGBADDR_S  in  5/5  decode-stage read addresses.
REQ-012 WRITEC_W_R / REGCADDR_W_R / REGC_W_R  out  1/5/32  registered write port to the register file.
REQ-013 HAZARD_S  out  1  combinational: a read address targets a pending destination.
REQ-014 WB_STALL_M  out  1  combinational: the ALU request was not granted this cycle.
REQ-015 LDQ_FULL  out  1  load queue holds LDQ_DEPTH entries.
REQ-016 PROTO_ERR  out  1  sticky protocol-error flag.

Function
REQ-017 Exactly one requester is granted per cycle; priority is load return > forced CE > ALU > CE (round-robin CE0/CE1).
REQ-018 LD_VALID always wins the grant; its destination is popped from the load queue in the same cycle.
REQ-019 WB_STALL_M = ALU_WE_M and the ALU is not granted.
REQ-020 CE round-robin: the pointer toggles after every CE grant; with one CE valid, that CE wins. Reset pointer = CE0.
REQ-021 Starvation: a 4-bit counter increments on each cycle in which any CEn_VALID is high and no CE is granted, and clears on any CE grant.
REQ-022 Forced CE: when the counter equals STARVE_LIMIT, the CE ranks above the ALU and the counter saturates until the next CE grant.
REQ-023 Grant-to-write latency is 1 cycle: WRITEC_W_R, REGCADDR_W_R and REGC_W_R register the granted request.
REQ-024 A grant to address 0 consumes the request and pops/clears as usual, but WRITEC_W_R stays 0.
REQ-025 Load queue: LD_ISSUE_E pushes LD_ADDR_E; a push and a pop in the same cycle are both legal when full or empty-then-push (empty with simultaneous issue and return is an error, see REQ-029).
REQ-026 CE destination: each CE holds one outstanding-destination register plus a pending bit, set on CEn_ISSUE_E and cleared on CEn transfer; CEn_READY is never asserted unless pending.
REQ-027 Scoreboard: 32 busy bits; each bit is set on issue of that destination and cleared at the grant cycle. When set and clear hit the same bit in one cycle, set wins. Bit 0 is never set.
REQ-028 HAZARD_S = busy[REGAADDR_S] | busy[REGBADDR_S].
REQ-029 PROTO_ERR sets on any of the following, and the offending event is otherwise ignored:
- LD_VALID with the queue empty;
- LD_ISSUE_E while LDQ_FULL with no pop;
- CEn_ISSUE_E while CEn pending;
- CEn_VALID while not pending.

Reset
REQ-030 While RESET_D1_R is high at a clock edge:
- all queues, pending bits, busy bits and counters clear;
- RR pointer goes to CE0;
- all outputs go to 0 on the next cycle, including the registered write port and PROTO_ERR;
- a reset mid-transfer discards the in-flight grant.

Verification
REQ-031 ALU_WE_M=1, addr 5, data 0x1234 alone -> next cycle WRITEC_W_R=1, REGCADDR_W_R=5, REGC_W_R=0x1234; WB_STALL_M=0.
REQ-032 Load to r7 issued, then LD_VALID (0xAAAA) in the same cycle as ALU_WE_M (r3) -> the load writes r7, WB_STALL_M=1 for one cycle, and r3 is written the following cycle; HAZARD_S is high while r7 is read until the grant.
REQ-033 STARVE_LIMIT=4, ALU_WE_M held high every cycle, CE0_VALID held high -> CE0_READY asserts on the 5th cycle, with WB_STALL_M=1 in that cycle.
REQ-034 CE0 and CE1 both valid and both pending, no ALU request -> grants alternate CE0, CE1; each READY is high for exactly one cycle.
REQ-035 LDQ_DEPTH=2: issue 3 loads without returns -> LDQ_FULL=1 after the second and PROTO_ERR=1 after the third; a later LD_VALID writes the first destination.
REQ-036 Issue a load to r0 and return it -> no write, HAZARD_S stays 0 on reads of r0; reset asserted mid-stream -> all outputs are 0 on the next cycle.
